// File: rtl/wb_pkg.sv
// Shared constants and result-entry type for the writeback arbiter slice.
// Default sizes match the accelerator register file write port.
package wb_pkg;

    localparam int WB_NUM_SRC    = 4;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry result buffer for one writeback source; entry 0 is always the head.
// Both entries' addresses are exposed so the arbiter can answer hazard queries.
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ADDR_WIDTH-1:0]   push_addr,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic [ADDR_WIDTH-1:0]   head_addr,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [1:0]              count,
    output logic [1:0]              ent_vld,
    output logic [2*ADDR_WIDTH-1:0] ent_addr
);

    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            count_q;

    // Payload registers carry no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    addr_q[count_q[0]] <= push_addr;
                    data_q[count_q[0]] <= push_data;
                    count_q            <= count_q + 2'd1;
                end
                2'b01: begin
                    addr_q[0] <= addr_q[1];
                    data_q[0] <= data_q[1];
                    count_q   <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        addr_q[0] <= push_addr;
                        data_q[0] <= push_data;
                    end else begin
                        addr_q[0] <= addr_q[1];
                        data_q[0] <= data_q[1];
                        addr_q[1] <= push_addr;
                        data_q[1] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_addr = addr_q[0];
    assign head_data = data_q[0];
    assign count     = count_q;
    assign ent_vld   = {count_q == 2'd2, count_q != 2'd0};
    assign ent_addr  = {addr_q[1], addr_q[0]};

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: per-source 2-deep buffers feeding the single
// register-file write port through a registered stage, plus a RAW hazard query.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          wen,
    output logic [ADDR_WIDTH-1:0]         addr_w,
    output logic [DATA_WIDTH-1:0]         data_w,
    input  logic [ADDR_WIDTH-1:0]         pend_addr,
    output logic                          pend_hit
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [1:0]              fifo_count [NUM_SRC];
    logic [ADDR_WIDTH-1:0]   head_addr  [NUM_SRC];
    logic [DATA_WIDTH-1:0]   head_data  [NUM_SRC];
    logic [1:0]              ent_vld    [NUM_SRC];
    logic [2*ADDR_WIDTH-1:0] ent_addr   [NUM_SRC];
    logic [NUM_SRC-1:0]      push;
    logic [NUM_SRC-1:0]      pop;
    logic [NUM_SRC-1:0]      nonempty;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        win;
    logic [PTR_W-1:0]        scan_idx;
    logic                    found;
    logic                    hit;

    genvar gi;
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
        // Ready ignores a same-cycle pop so it never depends on arbitration.
        assign src_ready[gi] = ~rst && (fifo_count[gi] != 2'd2);
        assign push[gi]      = src_valid[gi] & src_ready[gi];
        assign nonempty[gi]  = (fifo_count[gi] != 2'd0);

        wb_skid_fifo #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[gi]),
            .pop       (pop[gi]),
            .push_addr (src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .push_data (src_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .head_addr (head_addr[gi]),
            .head_data (head_data[gi]),
            .count     (fifo_count[gi]),
            .ent_vld   (ent_vld[gi]),
            .ent_addr  (ent_addr[gi])
        );
    end

    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && nonempty[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
            scan_idx = (scan_idx == PTR_W'(NUM_SRC - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_comb begin
        pop = '0;
        if (found) begin
            pop[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PTR_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        end
    end

    // Register 0 is hardwired zero: such results are popped but never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen    <= 1'b0;
            addr_w <= '0;
            data_w <= '0;
        end else if (found) begin
            wen    <= (head_addr[win] != '0);
            addr_w <= head_addr[win];
            data_w <= head_data[win];
        end else begin
            wen    <= 1'b0;
        end
    end

    always_comb begin
        hit = wen && (addr_w == pend_addr);
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int e = 0; e < 2; e++) begin
                if (ent_vld[i][e] && (ent_addr[i][e*ADDR_WIDTH +: ADDR_WIDTH] == pend_addr)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign pend_hit = hit && (pend_addr != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] src_data;
    logic            wen;
    logic [AW-1:0]   addr_w;
    logic [DW-1:0]   data_w;
    logic [AW-1:0]   pend_addr;
    logic            pend_hit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .wen       (wen),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .pend_addr (pend_addr),
        .pend_hit  (pend_hit)
    );

    // Reference model: one queue of {addr,data} per source, a round-robin
    // start index, and the expected registered write port.
    bit [AW+DW-1:0] mq [N][$];
    int             mptr   = 0;
    logic           m_wen  = 1'b0;
    logic [AW-1:0]  m_addr = '0;
    logic [DW-1:0]  m_data = '0;

    always @(posedge clk) begin : model
        bit [N-1:0]     acc;
        bit [AW+DW-1:0] e;
        int             w;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mptr   = 0;
            m_wen  = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            for (int i = 0; i < N; i++) acc[i] = src_valid[i] && (mq[i].size() < 2);
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
            if (w >= 0) begin
                e      = mq[w].pop_front();
                m_addr = e[AW+DW-1:DW];
                m_data = e[DW-1:0];
                m_wen  = (e[AW+DW-1:DW] != 0);
                mptr   = (w + 1) % N;
            end else begin
                m_wen = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (acc[i]) mq[i].push_back({src_addr[i*AW +: AW], src_data[i*DW +: DW]});
        end
    end

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !rst && (mq[i].size() < 2);
        return r;
    endfunction

    function automatic logic exp_pend(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (m_wen && m_addr == a) return 1'b1;
        for (int i = 0; i < N; i++)
            foreach (mq[i][j]) if (mq[i][j][AW+DW-1:DW] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
        src_valid[i]        = v;
        src_addr[i*AW +: AW] = a;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_valid = '1;
        src_addr  = $urandom;
        src_data  = {$urandom, $urandom, $urandom, $urandom};
        pend_addr = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (src_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", src_ready);
        end
        n_checks++;
        if ({wen, addr_w, data_w} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h expected all zero", wen, addr_w, data_w);
        end
        next_cycle();
        rst       = 1'b0;
        src_valid = '0;
        @(negedge clk);
        n_checks++;
        if (src_ready !== 4'hF) begin
            n_fail++; $display("FAIL post_reset_ready: got %b expected 1111", src_ready);
        end
        next_cycle();
    endtask

    task automatic test_single_push();
        pend_addr = 5'd5;
        set_src(2, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if (src_ready[2] !== 1'b1 || pend_hit !== 1'b0 || wen !== 1'b0) begin
            n_fail++; $display("FAIL single_c0: got ready2=%b pend=%b wen=%b expected 1 0 0", src_ready[2], pend_hit, wen);
        end
        next_cycle();
        src_valid = '0;
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b0 || pend_hit !== 1'b1) begin
            n_fail++; $display("FAIL single_c1: got wen=%b pend=%b expected 0 1", wen, pend_hit);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || addr_w !== 5'd5 || data_w !== 32'hDEADBEEF || pend_hit !== 1'b1) begin
            n_fail++; $display("FAIL single_c2: got wen=%b addr=%0d data=%h pend=%b expected 1 5 deadbeef 1",
                               wen, addr_w, data_w, pend_hit);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b0 || pend_hit !== 1'b0) begin
            n_fail++; $display("FAIL single_c3: got wen=%b pend=%b expected 0 0", wen, pend_hit);
        end
        next_cycle();
    endtask

    task automatic test_all_four();
        logic [DW-1:0] d [N];
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            d[i] = $urandom;
            set_src(i, 1'b1, AW'(i + 1), d[i]);
        end
        next_cycle();
        src_valid = '0;
        next_cycle();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            n_checks++;
            if (wen !== 1'b1 || addr_w !== AW'(k + 1) || data_w !== d[k]) begin
                n_fail++; $display("FAIL all_four_%0d: got wen=%b addr=%0d data=%h expected 1 %0d %h",
                                   k, wen, addr_w, data_w, k + 1, d[k]);
            end
            next_cycle();
        end
        // Pointer should have wrapped to 0: source 0 beats source 3.
        set_src(0, 1'b1, 5'd8, 32'h0000_0008);
        set_src(3, 1'b1, 5'd7, 32'h0000_0007);
        next_cycle();
        src_valid = '0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || addr_w !== 5'd8) begin
            n_fail++; $display("FAIL ptr_wrap_first: got wen=%b addr=%0d expected 1 8", wen, addr_w);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || addr_w !== 5'd7) begin
            n_fail++; $display("FAIL ptr_wrap_second: got wen=%b addr=%0d expected 1 7", wen, addr_w);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int  sent0 = 0, got0 = 0, last = -1;
        bit  saw_block = 0;
        for (int c = 0; c < 48; c++) begin
            set_src(0, sent0 < 4, AW'(10 + sent0), 32'hA000_0000 + sent0);
            for (int i = 1; i < N; i++)
                set_src(i, c < 30, AW'($urandom_range(1, 31)), {8'(8'h10 + i), 24'($urandom)});
            pend_addr = AW'($urandom_range(0, 31));
            @(negedge clk);
            n_checks++;
            if (src_ready !== exp_ready() || pend_hit !== exp_pend(pend_addr)) begin
                n_fail++; $display("FAIL bp_ready_pend: got ready=%b pend=%b expected %b %b",
                                   src_ready, pend_hit, exp_ready(), exp_pend(pend_addr));
            end
            n_checks++;
            if (wen !== m_wen || (m_wen && (addr_w !== m_addr || data_w !== m_data))) begin
                n_fail++; $display("FAIL bp_write: got wen=%b addr=%0d data=%h expected %b %0d %h",
                                   wen, addr_w, data_w, m_wen, m_addr, m_data);
            end
            if (!src_ready[0] && src_valid[0]) saw_block = 1;
            if (wen && data_w[31:24] == 8'hA0) begin
                n_checks++;
                if (data_w[23:0] !== 24'(got0) || (last >= 0 && c - last > N)) begin
                    n_fail++; $display("FAIL bp_src0_order: got seq=%0d gap=%0d expected seq=%0d gap<=%0d",
                                       data_w[23:0], c - last, got0, N);
                end
                got0++;
                last = c;
            end
            if (src_valid[0] && src_ready[0]) sent0++;
            next_cycle();
        end
        src_valid = '0;
        n_checks++;
        if (got0 !== 4 || !saw_block) begin
            n_fail++; $display("FAIL bp_summary: got writes=%0d blocked=%0d expected 4 1", got0, saw_block);
        end
    endtask

    task automatic test_addr_zero();
        src_valid = '0;
        pend_addr = '0;
        for (int k = 0; k < 6; k++) next_cycle();
        set_src(1, 1'b1, 5'd0, 32'h0000_1234);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (wen !== 1'b0 || src_ready[1] !== 1'b1 || pend_hit !== 1'b0) begin
                n_fail++; $display("FAIL addr_zero_%0d: got wen=%b ready1=%b pend=%b expected 0 1 0",
                                   k, wen, src_ready[1], pend_hit);
            end
            next_cycle();
            src_valid = '0;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(20 + i), $urandom);
        for (int k = 0; k < 3; k++) next_cycle();
        rst       = 1'b1;
        pend_addr = 5'd21;
        @(negedge clk);
        n_checks++;
        if (src_ready !== '0) begin
            n_fail++; $display("FAIL mid_reset_ready: got %b expected 0000", src_ready);
        end
        next_cycle();
        rst       = 1'b0;
        src_valid = '0;
        @(negedge clk);
        n_checks++;
        if ({wen, addr_w, data_w} !== '0 || pend_hit !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_out: got wen=%b addr=%0d data=%h pend=%b expected all zero",
                               wen, addr_w, data_w, pend_hit);
        end
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (wen !== 1'b0 || pend_hit !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset_drain_%0d: got wen=%b pend=%b expected 0 0", k, wen, pend_hit);
            end
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [10];
        logic [DW-1:0] d [10];
        for (int k = 0; k < 10; k++) begin
            a[k] = AW'($urandom_range(1, 31));
            d[k] = $urandom;
        end
        for (int k = 0; k < 13; k++) begin
            if (k < 10) set_src(3, 1'b1, a[k], d[k]);
            else src_valid = '0;
            @(negedge clk);
            if (k < 10) begin
                n_checks++;
                if (src_ready[3] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, src_ready[3]);
                end
            end
            n_checks++;
            if (k >= 2 && k < 12) begin
                if (wen !== 1'b1 || addr_w !== a[k-2] || data_w !== d[k-2]) begin
                    n_fail++; $display("FAIL b2b_write_%0d: got wen=%b addr=%0d data=%h expected 1 %0d %h",
                                       k, wen, addr_w, data_w, a[k-2], d[k-2]);
                end
            end else if (wen !== 1'b0) begin
                n_fail++; $display("FAIL b2b_idle_%0d: got wen=%b expected 0", k, wen);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++)
                set_src(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom);
            pend_addr = AW'($urandom_range(0, 7));
            @(negedge clk);
            n_checks++;
            if (src_ready !== exp_ready() || pend_hit !== exp_pend(pend_addr)) begin
                n_fail++; $display("FAIL rand_ready_pend_%0d: got ready=%b pend=%b expected %b %b",
                                   c, src_ready, pend_hit, exp_ready(), exp_pend(pend_addr));
            end
            n_checks++;
            if (wen !== m_wen || addr_w !== m_addr || data_w !== m_data) begin
                n_fail++; $display("FAIL rand_write_%0d: got wen=%b addr=%0d data=%h expected %b %0d %h",
                                   c, wen, addr_w, data_w, m_wen, m_addr, m_data);
            end
            next_cycle();
        end
        rst       = 1'b0;
        src_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        pend_addr = '0;
        test_reset();
        test_single_push();
        test_all_four();
        test_backpressure();
        test_addr_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
